// File: rtl/mmcm_ps_pkg.sv
// rtl/mmcm_ps_pkg.sv - shared types and defaults for the MMCM phase-shift responder
package mmcm_ps_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } ps_state_t;

  localparam int PS_STEPS_PER_VCO    = 56;
  localparam int PS_DONE_LATENCY_DEF = 12;

endpackage

// File: rtl/mmcm_ps_phase_acc.sv
// rtl/mmcm_ps_phase_acc.sv - modular fine-phase position counter with slip pulse and direction
module mmcm_ps_phase_acc #(
  parameter int STEPS_PER_CYCLE = 448,
  parameter int MOD_W           = $clog2(STEPS_PER_CYCLE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_en,
  input  logic             dir,
  output logic [MOD_W-1:0] phase_mod,
  output logic             cycle_slip,
  output logic             slip_dir
);

  localparam logic [MOD_W-1:0] LAST = MOD_W'(STEPS_PER_CYCLE - 1);

  logic [MOD_W-1:0] mod_q, mod_d;
  logic             slip_q, slip_d;
  logic             slip_dir_q, slip_dir_d;

  always_comb begin
    mod_d      = mod_q;
    slip_d     = 1'b0;
    slip_dir_d = slip_dir_q;
    if (step_en) begin
      if (dir) begin
        if (mod_q == LAST) begin
          mod_d      = '0;
          slip_d     = 1'b1;
          slip_dir_d = 1'b1;
        end else begin
          mod_d = mod_q + 1'b1;
        end
      end else begin
        if (mod_q == '0) begin
          mod_d      = LAST;
          slip_d     = 1'b1;
          slip_dir_d = 1'b0;
        end else begin
          mod_d = mod_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mod_q      <= '0;
      slip_q     <= 1'b0;
      slip_dir_q <= 1'b0;
    end else begin
      mod_q      <= mod_d;
      slip_q     <= slip_d;
      slip_dir_q <= slip_dir_d;
    end
  end

  assign phase_mod  = mod_q;
  assign cycle_slip = slip_q;
  assign slip_dir   = slip_dir_q;

endmodule

// File: rtl/mmcm_ps_responder.sv
// rtl/mmcm_ps_responder.sv - MMCM dynamic phase-shift port responder (psen/psincdec -> psdone)
// Optional accepted-step counters enabled by MMCM_PS_RESP_STATS_EN.
module mmcm_ps_responder
  import mmcm_ps_pkg::*;
#(
  parameter int PSDONE_LATENCY  = PS_DONE_LATENCY_DEF,
  parameter int PHASE_W         = 32,
  parameter int STEPS_PER_CYCLE = PS_STEPS_PER_VCO * 8,
  parameter int MOD_W           = $clog2(STEPS_PER_CYCLE)
) (
  input  logic                      psclk,
  input  logic                      reset,
  input  logic                      psen,
  input  logic                      psincdec,
  output logic                      psdone,
  output logic                      ps_busy,
  output logic signed [PHASE_W-1:0] phase_steps,
  output logic [MOD_W-1:0]          phase_mod,
  output logic                      cycle_slip,
  output logic                      slip_dir,
  output logic                      proto_err,
  input  logic                      clear_err,
  output logic [31:0]               inc_count,
  output logic [31:0]               dec_count
);

  localparam logic [7:0] CNT_LOAD = 8'(PSDONE_LATENCY - 1);

  ps_state_t                 state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      dir_q, dir_d;
  logic                      proto_err_q, proto_err_d;
  logic signed [PHASE_W-1:0] phase_steps_q, phase_steps_d;
  logic                      step_en;
  logic                      violation;

  // step_en fires on the edge into DONE so every phase output is already
  // updated while psdone is high.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    step_en   = 1'b0;
    violation = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (psen) begin
          dir_d   = psincdec;
          cnt_d   = CNT_LOAD;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        cnt_d     = cnt_q - 8'd1;
        violation = psen;
        if (cnt_d == 8'd0) begin
          state_d = DONE;
          step_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    proto_err_d   = violation | (proto_err_q & ~clear_err);
    phase_steps_d = phase_steps_q;
    if (step_en) begin
      phase_steps_d = dir_q ? phase_steps_q + PHASE_W'(1) : phase_steps_q - PHASE_W'(1);
    end
  end

  always_ff @(posedge psclk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dir_q         <= 1'b0;
      proto_err_q   <= 1'b0;
      phase_steps_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      proto_err_q   <= proto_err_d;
      phase_steps_q <= phase_steps_d;
    end
  end

  mmcm_ps_phase_acc #(
    .STEPS_PER_CYCLE(STEPS_PER_CYCLE),
    .MOD_W          (MOD_W)
  ) u_phase_acc (
    .clk       (psclk),
    .reset     (reset),
    .step_en   (step_en),
    .dir       (dir_q),
    .phase_mod (phase_mod),
    .cycle_slip(cycle_slip),
    .slip_dir  (slip_dir)
  );

  assign psdone      = (state_q == DONE);
  assign ps_busy     = (state_q == SHIFT);
  assign phase_steps = phase_steps_q;
  assign proto_err   = proto_err_q;

`ifdef MMCM_PS_RESP_STATS_EN
  logic [31:0] inc_count_q, inc_count_d;
  logic [31:0] dec_count_q, dec_count_d;

  always_comb begin
    inc_count_d = inc_count_q;
    dec_count_d = dec_count_q;
    if (step_en) begin
      if (dir_q) inc_count_d = inc_count_q + 32'd1;
      else       dec_count_d = dec_count_q + 32'd1;
    end
  end

  always_ff @(posedge psclk) begin
    if (reset) begin
      inc_count_q <= '0;
      dec_count_q <= '0;
    end else begin
      inc_count_q <= inc_count_d;
      dec_count_q <= dec_count_d;
    end
  end

  assign inc_count = inc_count_q;
  assign dec_count = dec_count_q;
`else
  assign inc_count = '0;
  assign dec_count = '0;
`endif

endmodule
